// File: rtl/slow_pulse_rate_monitor_if.sv
// Bus between the pulse-rate monitor and its controller: run control, window
// setup, interrupt handshake and the published per-window results.
interface slow_pulse_rate_monitor_if #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
);
    logic             en;
    logic             pulse_in;
    logic [WIN_W-1:0] win_len;
    logic [CNT_W-1:0] threshold;
    logic             irq_ack;
    logic [CNT_W-1:0] last_count;
    logic             count_valid;
    logic             overflow;
    logic             irq;

    modport master (
        output en, pulse_in, win_len, threshold, irq_ack,
        input  last_count, count_valid, overflow, irq
    );

    modport slave (
        input  en, pulse_in, win_len, threshold, irq_ack,
        output last_count, count_valid, overflow, irq
    );
endinterface

// File: rtl/slow_pulse_rate_monitor.sv
// Counts rising edges of a synchronized pulse over back-to-back windows of
// slow_clk cycles, publishes each window's count and raises a sticky irq.
module slow_pulse_rate_monitor #(
    parameter int CNT_W = 8,
    parameter int WIN_W = 16
) (
    input logic                 slow_clk,
    input logic                 rst,
    slow_pulse_rate_monitor_if.slave mon
);
    typedef enum logic {IDLE, RUN} state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state, state_n;
    logic             pulse_d;
    logic [WIN_W-1:0] win_q, win_q_n;
    logic [WIN_W-1:0] win_cnt, win_cnt_n;
    logic [CNT_W-1:0] evt_cnt, evt_cnt_n;
    logic             sat, sat_n;
    logic [CNT_W-1:0] last_count, last_count_n;
    logic             overflow, overflow_n;
    logic             count_valid, count_valid_n;
    logic             irq, irq_n;

    logic             evt;
    logic             close;
    logic             at_max;
    logic [CNT_W-1:0] total;
    logic             total_sat;

    // The close-cycle event is folded into total so it lands in the closing window.
    assign evt       = mon.pulse_in & ~pulse_d;
    assign close     = (state == RUN) && (win_cnt == win_q - WIN_W'(1));
    assign at_max    = (evt_cnt == CNT_MAX);
    assign total     = (evt && !at_max) ? evt_cnt + CNT_W'(1) : evt_cnt;
    assign total_sat = sat | (evt & at_max);

    always_comb begin
        state_n       = state;
        win_q_n       = win_q;
        win_cnt_n     = win_cnt;
        evt_cnt_n     = evt_cnt;
        sat_n         = sat;
        last_count_n  = last_count;
        overflow_n    = overflow;
        count_valid_n = 1'b0;
        irq_n         = mon.irq_ack ? 1'b0 : irq;

        case (state)
            IDLE: begin
                win_cnt_n = '0;
                evt_cnt_n = '0;
                sat_n     = 1'b0;
                if (mon.en && (mon.win_len != '0)) begin
                    win_q_n = mon.win_len;
                    state_n = RUN;
                end
            end
            RUN: begin
                if (close) begin
                    last_count_n  = total;
                    overflow_n    = total_sat;
                    count_valid_n = 1'b1;
                    win_cnt_n     = '0;
                    evt_cnt_n     = '0;
                    sat_n         = 1'b0;
                    if ((mon.threshold != '0) && (total >= mon.threshold)) begin
                        irq_n = 1'b1;
                    end
                    if (!mon.en) begin
                        state_n = IDLE;
                    end
                end else if (!mon.en) begin
                    // Partial window is dropped; IDLE clears the counters.
                    state_n = IDLE;
                end else begin
                    win_cnt_n = win_cnt + WIN_W'(1);
                    evt_cnt_n = total;
                    sat_n     = total_sat;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

    // Edge register resets high so a level already asserted is not an event.
    always_ff @(posedge slow_clk) begin
        if (rst) begin
            state       <= IDLE;
            pulse_d     <= 1'b1;
            win_q       <= '0;
            win_cnt     <= '0;
            evt_cnt     <= '0;
            sat         <= 1'b0;
            last_count  <= '0;
            overflow    <= 1'b0;
            count_valid <= 1'b0;
            irq         <= 1'b0;
        end else begin
            state       <= state_n;
            pulse_d     <= mon.pulse_in;
            win_q       <= win_q_n;
            win_cnt     <= win_cnt_n;
            evt_cnt     <= evt_cnt_n;
            sat         <= sat_n;
            last_count  <= last_count_n;
            overflow    <= overflow_n;
            count_valid <= count_valid_n;
            irq         <= irq_n;
        end
    end

    assign mon.last_count  = last_count;
    assign mon.count_valid = count_valid;
    assign mon.overflow    = overflow;
    assign mon.irq         = irq;
endmodule
